// File: rtl/delta_comp_pkg.sv
// Shared types and helpers for the streaming delta compressor.
//   state_e         : control FSM states
//   mask_bit()      : bit k of a P-bit slot mask (low P bits set)
//   inv_fill_bit()  : bit k of a word whose every P-bit slot holds INV (1 then P-1 zeros)
//   delta_in_range(): signed delta fits a P-bit slot without using the INV code
// Helpers take P at run time; PK_W bounds the lane width they can handle.
package delta_comp_pkg;

  localparam int unsigned PK_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_PACK,
    ST_RAW_PEND,
    ST_FLUSH
  } state_e;

  function automatic logic mask_bit(input logic [31:0] k, input logic [31:0] p);
    return k < p;
  endfunction

  // Slots are aligned to bit 0 since P divides the lane width, so the slot
  // MSBs sit where (k+1) is a multiple of P.
  function automatic logic inv_fill_bit(input logic [31:0] k, input logic [31:0] p);
    return ((k + 32'd1) & (p - 32'd1)) == 32'd0;
  endfunction

  // Fits in P signed bits when everything from bit P-1 up is pure sign;
  // the most negative P-bit code is excluded because it marks an empty slot.
  function automatic logic delta_in_range(input logic [PK_W-1:0] d, input logic [31:0] p);
    logic [PK_W-1:0] hi;
    logic [PK_W-1:0] lo_mask;
    hi      = $signed(d) >>> (p - 32'd1);
    lo_mask = (PK_W'(1) << p) - PK_W'(1);
    return ((hi == '0) || (hi == '1)) && ((d & lo_mask) != (PK_W'(1) << (p - 32'd1)));
  endfunction

endpackage

// File: rtl/delta_lane_pack.sv
// One lane of the delta compressor: delta subtract, range check and slot insert.
//   i_last      : previous accepted value of this lane
//   i_in        : current input value
//   i_comp      : current packed word of this lane
//   i_ptr       : slot index to write (0 = most significant slot)
//   i_p         : slot width in bits
//   o_ovf       : delta does not fit a slot
//   o_comp_next : i_comp with the delta written into slot i_ptr
module delta_lane_pack
  import delta_comp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PTR_W      = 3
) (
  input  logic [DATA_WIDTH-1:0] i_last,
  input  logic [DATA_WIDTH-1:0] i_in,
  input  logic [DATA_WIDTH-1:0] i_comp,
  input  logic [PTR_W-1:0]      i_ptr,
  input  logic [31:0]           i_p,
  output logic                  o_ovf,
  output logic [DATA_WIDTH-1:0] o_comp_next
);

  logic [DATA_WIDTH-1:0] w_delta;
  logic [PK_W-1:0]       w_delta_x;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [31:0]           w_sh;

  assign w_delta   = i_last - i_in;
  assign w_delta_x = PK_W'($signed(w_delta));
  assign o_ovf     = !delta_in_range(w_delta_x, i_p);

  always_comb begin
    w_mask = '0;
    for (int k = 0; k < DATA_WIDTH; k++) w_mask[k] = mask_bit(32'(k), i_p);
  end

  // Slot 0 is the top P bits, so slot i starts DW-(i+1)*P bits up.
  assign w_sh        = 32'(DATA_WIDTH) - (32'(i_ptr) + 32'd1) * i_p;
  assign o_comp_next = (i_comp & ~(w_mask << w_sh)) | ((w_delta & w_mask) << w_sh);

endmodule

// File: rtl/delta_compressor_stream.sv
// Streaming per-lane delta compressor with ready/valid on both sides.
//   clk, rst_n     : clock, async active-low reset
//   tracing        : enable; falling edge flushes a partial word
//   cfg_slots_log2 : log2 slots per word, latched in IDLE (illegal -> 1)
//   valid_in/ready_in/vector_in    : input vector stream
//   valid_out/ready_out/vector_out : output word stream (one-word register)
//   v_out_comp     : 1 = packed deltas, 0 = raw vector
//   slots_used     : valid deltas in a packed word, 0 for raw
//   raw_count      : saturating count of raw words emitted
module delta_compressor_stream
  import delta_comp_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_SLOTS  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               tracing,
  input  logic [$clog2(MAX_SLOTS)-1:0]       cfg_slots_log2,
  input  logic                               valid_in,
  output logic                               ready_in,
  input  logic [N-1:0][DATA_WIDTH-1:0]       vector_in,
  output logic                               valid_out,
  input  logic                               ready_out,
  output logic [N-1:0][DATA_WIDTH-1:0]       vector_out,
  output logic                               v_out_comp,
  output logic [$clog2(MAX_SLOTS):0]         slots_used,
  output logic [CNT_WIDTH-1:0]               raw_count
);

  localparam int LOG_W = $clog2(MAX_SLOTS);
  localparam int SU_W  = LOG_W + 1;
  typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

  state_e           r_state;
  logic [LOG_W-1:0] r_slots_log2;
  logic [SU_W-1:0]  r_ptr;
  vec_t             r_last, r_comp, r_pend;

  vec_t             r_vout;
  logic             r_valid_out, r_comp_flag;
  logic [SU_W-1:0]  r_slots_used;
  logic [CNT_WIDTH-1:0] r_raw_count;

  logic [LOG_W-1:0]      w_cfg_clamped;
  logic [SU_W-1:0]       w_s;
  logic [31:0]           w_p;
  logic [DATA_WIDTH-1:0] w_inv;
  vec_t                  w_inv_vec, w_comp_next, w_ld_data;
  logic [N-1:0]          w_ovf;
  logic                  w_any_ovf, w_full, w_free, w_acc;
  logic                  w_ld, w_ld_raw;
  logic [SU_W-1:0]       w_ld_slots;

  assign w_cfg_clamped = (cfg_slots_log2 == '0 || 32'(cfg_slots_log2) > 32'(LOG_W))
                         ? LOG_W'(1) : cfg_slots_log2;
  assign w_s = SU_W'(1) << r_slots_log2;
  assign w_p = 32'(DATA_WIDTH) >> r_slots_log2;

  always_comb begin
    w_inv = '0;
    for (int k = 0; k < DATA_WIDTH; k++) w_inv[k] = inv_fill_bit(32'(k), w_p);
  end
  assign w_inv_vec = {N{w_inv}};

  for (genvar g = 0; g < N; g++) begin : g_lane
    delta_lane_pack #(.DATA_WIDTH(DATA_WIDTH), .PTR_W(SU_W)) u_lane (
      .i_last      (r_last[g]),
      .i_in        (vector_in[g]),
      .i_comp      (r_comp[g]),
      .i_ptr       (r_ptr),
      .i_p         (w_p),
      .o_ovf       (w_ovf[g]),
      .o_comp_next (w_comp_next[g])
    );
  end

  assign w_any_ovf = |w_ovf;
  assign w_full    = (r_ptr + SU_W'(1)) == w_s;
  // Output register can take a word when empty or being drained this cycle.
  assign w_free    = !r_valid_out || ready_out;
  assign ready_in  = tracing && (r_state == ST_PRIME || r_state == ST_PACK) && w_free;
  assign w_acc     = valid_in && ready_in;

  // Which word (if any) enters the output register this cycle.
  always_comb begin
    w_ld       = 1'b0;
    w_ld_raw   = 1'b0;
    w_ld_data  = vector_in;
    w_ld_slots = '0;
    case (r_state)
      ST_PRIME: if (w_acc) begin
        w_ld     = 1'b1;
        w_ld_raw = 1'b1;
      end
      ST_PACK: if (w_acc) begin
        if (!w_any_ovf) begin
          if (w_full) begin
            w_ld       = 1'b1;
            w_ld_data  = w_comp_next;
            w_ld_slots = w_s;
          end
        end else if (r_ptr == '0) begin
          w_ld     = 1'b1;
          w_ld_raw = 1'b1;
        end else begin
          // Close the partial word first; the raw vector follows from r_pend.
          w_ld       = 1'b1;
          w_ld_data  = r_comp;
          w_ld_slots = r_ptr;
        end
      end
      ST_RAW_PEND: if (w_free) begin
        w_ld      = 1'b1;
        w_ld_raw  = 1'b1;
        w_ld_data = r_pend;
      end
      ST_FLUSH: if (r_ptr != '0 && w_free) begin
        w_ld       = 1'b1;
        w_ld_data  = r_comp;
        w_ld_slots = r_ptr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_slots_log2 <= LOG_W'(1);
      r_ptr        <= '0;
      r_last       <= '0;
      r_comp       <= '0;
      r_pend       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_slots_log2 <= w_cfg_clamped;
          r_ptr        <= '0;
          if (tracing) r_state <= ST_PRIME;
        end
        ST_PRIME: begin
          if (!tracing) r_state <= ST_FLUSH;
          else if (w_acc) begin
            r_last  <= vector_in;
            r_comp  <= w_inv_vec;
            r_ptr   <= '0;
            r_state <= ST_PACK;
          end
        end
        ST_PACK: begin
          if (!tracing) r_state <= ST_FLUSH;
          else if (w_acc) begin
            r_last <= vector_in;
            if (!w_any_ovf) begin
              if (w_full) begin
                r_comp <= w_inv_vec;
                r_ptr  <= '0;
              end else begin
                r_comp <= w_comp_next;
                r_ptr  <= r_ptr + SU_W'(1);
              end
            end else if (r_ptr != '0) begin
              r_pend  <= vector_in;
              r_comp  <= w_inv_vec;
              r_ptr   <= '0;
              r_state <= ST_RAW_PEND;
            end
          end
        end
        ST_RAW_PEND: if (w_free) r_state <= tracing ? ST_PACK : ST_FLUSH;
        ST_FLUSH: begin
          if (r_ptr == '0) r_state <= ST_IDLE;
          else if (w_free) begin
            r_ptr   <= '0;
            r_comp  <= w_inv_vec;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vout       <= '0;
      r_valid_out  <= 1'b0;
      r_comp_flag  <= 1'b0;
      r_slots_used <= '0;
      r_raw_count  <= '0;
    end else if (w_ld) begin
      r_vout       <= w_ld_data;
      r_valid_out  <= 1'b1;
      r_comp_flag  <= !w_ld_raw;
      r_slots_used <= w_ld_slots;
      if (w_ld_raw && r_raw_count != '1) r_raw_count <= r_raw_count + CNT_WIDTH'(1);
    end else if (ready_out) begin
      r_valid_out <= 1'b0;
    end
  end

  assign vector_out = r_vout;
  assign valid_out  = r_valid_out;
  assign v_out_comp = r_comp_flag;
  assign slots_used = r_slots_used;
  assign raw_count  = r_raw_count;

endmodule

// File: tb/tb_delta_compressor_stream.sv
// Directed bench for delta_compressor_stream (N=2, DW=32, MAX_SLOTS=4, 3-bit raw counter).
module tb_delta_compressor_stream;

  logic             clk;
  logic             rst_n;
  logic             tracing;
  logic [1:0]       cfg_slots_log2;
  logic             valid_in;
  logic             ready_in;
  logic [1:0][31:0] vector_in;
  logic             valid_out;
  logic             ready_out;
  logic [1:0][31:0] vector_out;
  logic             v_out_comp;
  logic [2:0]       slots_used;
  logic [2:0]       raw_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic             comp;
    logic [2:0]       slots;
    logic [1:0][31:0] data;
  } word_t;
  word_t q[$];

  delta_compressor_stream #(.N(2), .DATA_WIDTH(32), .MAX_SLOTS(4), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .tracing(tracing), .cfg_slots_log2(cfg_slots_log2),
    .valid_in(valid_in), .ready_in(ready_in), .vector_in(vector_in),
    .valid_out(valid_out), .ready_out(ready_out), .vector_out(vector_out),
    .v_out_comp(v_out_comp), .slots_used(slots_used), .raw_count(raw_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every delivered word; inputs only change just after posedge.
  always @(negedge clk)
    if (rst_n && valid_out && ready_out) q.push_back({v_out_comp, slots_used, vector_out});

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    valid_in = 1'b1;
    vector_in[0] = a;
    vector_in[1] = b;
    #1;
    while (ready_in !== 1'b1 && n < 40) begin step(); n++; end
    checks++;
    if (ready_in !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout ready_in=%b required 1", ready_in);
    end
    step();
    valid_in = 1'b0;
  endtask

  task automatic start_session(input logic [1:0] cfg);
    cfg_slots_log2 = cfg;
    tracing = 1'b1;
    step();
    q.delete();
  endtask

  task automatic end_session();
    tracing = 1'b0;
    valid_in = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tracing = 1'b0; cfg_slots_log2 = 2'd2; valid_in = 1'b0;
    ready_out = 1'b1; vector_in = '0;
    repeat (2) step();
    checks++;
    if ({valid_out, ready_in, v_out_comp, slots_used, raw_count} !== 9'd0) begin
      errors++;
      $display("FAIL reset_flags got v%b r%b c%b s%0d n%0d required all 0",
               valid_out, ready_in, v_out_comp, slots_used, raw_count);
    end
    checks++;
    if (vector_out !== 64'd0) begin
      errors++; $display("FAIL reset_vector got %h required 0", vector_out);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_trace_start();
    word_t e0, e1;
    cfg_slots_log2 = 2'd2;
    tracing = 1'b1;
    #1;
    checks++;
    if (ready_in !== 1'b0) begin errors++; $display("FAIL idle_ready got %b required 0", ready_in); end
    step();
    q.delete();
    send(100, 200);
    checks++;
    if ({valid_out, v_out_comp, slots_used} !== 5'b10000 || vector_out !== {32'd200, 32'd100}) begin
      errors++;
      $display("FAIL start_raw got v%b c%b s%0d %h required raw 000000c8_00000064",
               valid_out, v_out_comp, slots_used, vector_out);
    end
    send(99, 201); send(97, 201); send(97, 190); send(96, 189);
    checks++;
    if ({valid_out, v_out_comp, slots_used} !== 5'b11100 ||
        vector_out !== {32'hFF000B01, 32'h01020001}) begin
      errors++;
      $display("FAIL start_packed got v%b c%b s%0d %h required packed s4 ff000b01_01020001",
               valid_out, v_out_comp, slots_used, vector_out);
    end
    step();
    e0 = {1'b0, 3'd0, 32'd200, 32'd100};
    e1 = {1'b1, 3'd4, 32'hFF000B01, 32'h01020001};
    checks++;
    if (q.size() != 2) begin errors++; $display("FAIL start_count got %0d required 2", q.size()); end
    else if (q[0] !== e0 || q[1] !== e1) begin
      errors++; $display("FAIL start_seq got %h %h required %h %h", q[0], q[1], e0, e1);
    end
    checks++;
    if (raw_count !== 3'd1) begin errors++; $display("FAIL start_rawcnt got %0d required 1", raw_count); end
    end_session();
  endtask

  task automatic test_overflow();
    word_t e1, e2;
    start_session(2'd2);
    send(0, 0); send(1, 0); send(500, 0);
    valid_in = 1'b1; vector_in = {32'd7, 32'd7};
    #1;
    checks++;
    if (ready_in !== 1'b0) begin errors++; $display("FAIL rawpend_ready got %b required 0", ready_in); end
    checks++;
    if ({valid_out, v_out_comp, slots_used} !== 5'b11001 ||
        vector_out !== {32'h00808080, 32'hFF808080}) begin
      errors++;
      $display("FAIL ovf_partial got v%b c%b s%0d %h required s1 00808080_ff808080",
               valid_out, v_out_comp, slots_used, vector_out);
    end
    step();
    valid_in = 1'b0;
    checks++;
    if ({valid_out, v_out_comp, slots_used} !== 5'b10000 || vector_out !== {32'd0, 32'd500}) begin
      errors++;
      $display("FAIL ovf_raw got v%b c%b s%0d %h required raw 00000000_000001f4",
               valid_out, v_out_comp, slots_used, vector_out);
    end
    step();
    e1 = {1'b1, 3'd1, 32'h00808080, 32'hFF808080};
    e2 = {1'b0, 3'd0, 32'd0, 32'd500};
    checks++;
    if (q.size() != 3) begin errors++; $display("FAIL ovf_count got %0d required 3", q.size()); end
    else if (q[1] !== e1 || q[2] !== e2) begin
      errors++; $display("FAIL ovf_seq got %h %h required %h %h", q[1], q[2], e1, e2);
    end
    checks++;
    if (raw_count !== 3'd3) begin errors++; $display("FAIL ovf_rawcnt got %0d required 3", raw_count); end
    end_session();
  endtask

  task automatic test_back_to_back();
    word_t e0, e1;
    start_session(2'd2);
    send(10, 20);
    ready_out = 1'b0;
    valid_in = 1'b1; vector_in = {32'd21, 32'd9};
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (ready_in !== 1'b0) begin errors++; $display("FAIL stall_ready c%0d got %b required 0", c, ready_in); end
      checks++;
      if (valid_out !== 1'b1 || vector_out !== {32'd20, 32'd10}) begin
        errors++;
        $display("FAIL stall_hold c%0d got v%b %h required v1 00000014_0000000a", c, valid_out, vector_out);
      end
      step();
    end
    ready_out = 1'b1;
    send(9, 21); send(7, 21); send(7, 10); send(6, 9);
    step();
    e0 = {1'b0, 3'd0, 32'd20, 32'd10};
    e1 = {1'b1, 3'd4, 32'hFF000B01, 32'h01020001};
    checks++;
    if (q.size() != 2) begin errors++; $display("FAIL stall_count got %0d required 2", q.size()); end
    else if (q[0] !== e0 || q[1] !== e1) begin
      errors++; $display("FAIL stall_seq got %h %h required %h %h", q[0], q[1], e0, e1);
    end
    checks++;
    if (raw_count !== 3'd4) begin errors++; $display("FAIL stall_rawcnt got %0d required 4", raw_count); end
    end_session();
  endtask

  task automatic test_flush();
    start_session(2'd2);
    send(0, 0); send(1, 2); send(3, 2);
    tracing = 1'b0;
    #1;
    checks++;
    if (ready_in !== 1'b0) begin errors++; $display("FAIL flush_ready got %b required 0", ready_in); end
    step();
    step();
    checks++;
    if ({valid_out, v_out_comp, slots_used} !== 5'b11010 ||
        vector_out !== {32'hFE008080, 32'hFFFE8080}) begin
      errors++;
      $display("FAIL flush_word got v%b c%b s%0d %h required s2 fe008080_fffe8080",
               valid_out, v_out_comp, slots_used, vector_out);
    end
    step();
    checks++;
    if (valid_out !== 1'b0 || ready_in !== 1'b0) begin
      errors++; $display("FAIL flush_idle got v%b r%b required v0 r0", valid_out, ready_in);
    end
    checks++;
    if (raw_count !== 3'd5) begin errors++; $display("FAIL flush_rawcnt got %0d required 5", raw_count); end
  endtask

  task automatic test_mode_change();
    logic [1:0] cfgs [3];
    cfgs[0] = 2'd1; cfgs[1] = 2'd0; cfgs[2] = 2'd3;
    for (int m = 0; m < 3; m++) begin
      start_session(cfgs[m]);
      send(0, 0);
      cfg_slots_log2 = 2'd2;
      send(32'hFFFFFED4, 0);
      tracing = 1'b0;
      step();
      step();
      checks++;
      if ({valid_out, v_out_comp, slots_used} !== 5'b11001 ||
          vector_out !== {32'h00008000, 32'h012C8000}) begin
        errors++;
        $display("FAIL mode_word cfg%0d got v%b c%b s%0d %h required s1 00008000_012c8000",
                 cfgs[m], valid_out, v_out_comp, slots_used, vector_out);
      end
      step();
    end
    checks++;
    if (raw_count !== 3'd7) begin errors++; $display("FAIL rawcnt_saturate got %0d required 7", raw_count); end
  endtask

  task automatic test_async_reset();
    start_session(2'd2);
    send(0, 0); send(1, 0);
    ready_out = 1'b0;
    send(500, 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || raw_count !== 3'd0) begin
      errors++; $display("FAIL async_reset got v%b n%0d required v0 n0", valid_out, raw_count);
    end
    checks++;
    if ({ready_in, v_out_comp, slots_used} !== 5'd0 || vector_out !== 64'd0) begin
      errors++;
      $display("FAIL async_reset_out got r%b c%b s%0d %h required all 0",
               ready_in, v_out_comp, slots_used, vector_out);
    end
    tracing = 1'b0;
    ready_out = 1'b1;
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_trace_start();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_mode_change();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not end in time");
    $fatal(1);
  end

endmodule

// File: doc/delta_compressor_stream.md
Name: delta_compressor_stream

Overview:
- Successor to the fixed delta compressor in the trace path between the filter/reduce stages and the trace buffer.
- Packs per-lane signed deltas of N consecutive vectors into DATA_WIDTH-bit words. Slots per word are selectable at run time.
- Adds what the fixed block lacks:
  - ready/valid back-pressure;
  - explicit flush of partially filled words on overflow or end of tracing;
  - an explicit raw base vector at each (re)start;
  - a raw-word statistics counter.

Parameters:
- N, 8, lanes per vector.
- DATA_WIDTH, 32, bits per lane.
- MAX_SLOTS, 4, maximum deltas per word. Power of two, ≥2, divides DATA_WIDTH.
- CNT_WIDTH, 16, width of the raw-word counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- tracing  in  1  compression enabled. The falling edge triggers a flush.
- cfg_slots_log2  in  $clog2(MAX_SLOTS)  log2 of slots per word; legal 1..log2(MAX_SLOTS). Sampled only in IDLE.
- valid_in  in  1  input vector valid.
- ready_in  out  1  input accepted this cycle when valid_in&ready_in&tracing.
- vector_in  in  N×DATA_WIDTH  input vector.
- valid_out  out  1  output word valid.
- ready_out  in  1  downstream (trace buffer) accepts.
- vector_out  out  N×DATA_WIDTH  packed or raw word.
- v_out_comp  out  1  1 = packed deltas, 0 = raw vector.
- slots_used  out  $clog2(MAX_SLOTS)+1  valid deltas in a packed word (0 for raw).
- raw_count  out  CNT_WIDTH  raw words emitted since reset. Saturating.

Behaviour:
- Derived values:
  - S = 1<<cfg_slots_log2 (latched as S_q);
  - P = DATA_WIDTH/S_q;
  - INV = 1 followed by P-1 zeros;
  - empty slot = INV;
  - valid delta range is [-(2^(P-1)-1), 2^(P-1)-1]. The most negative code is reserved for INV.
- Delta per lane: delta = last − in, modulo 2^DATA_WIDTH, interpreted signed. Overflow if any lane is out of range.
- Packing:
  - the first delta goes in the most significant slot (bits DATA_WIDTH-1 down to DATA_WIDTH-P);
  - later deltas fill downward;
  - unfilled slots read INV.
- Reset:
  - state=IDLE; valid_out=0; ready_in=0; v_out_comp=0; slots_used=0; raw_count=0;
  - vector_out, comp_reg and last cleared to 0; ptr=0.
- Output register holds one word. It may load when !valid_out or ready_out (the slot is free this cycle). valid_out holds with data stable until ready_out.
- ready_in = tracing & (state==PRIME or PACK) & output slot free & !pend_raw.
- States:
  - IDLE:
    - latch cfg;
    - go to PRIME when tracing=1.
  - PRIME:
    - on accept, emit vector_in raw (v_out_comp=0, slots_used=0);
    - last←in; ptr=0; go to PACK.
  - PACK, accept without overflow:
    - write the delta into slot ptr; ptr++;
    - if ptr reaches S_q, emit packed (slots_used=S_q), reset comp_reg to all INV, ptr=0;
    - last←in. Latency is 1 cycle from the accepting edge to valid_out.
  - PACK, accept with overflow and ptr==0:
    - emit in raw;
    - last←in.
  - PACK, accept with overflow and ptr>0:
    - emit the partial packed word (slots_used=ptr);
    - latch in into pend_raw and set last←in;
    - go to RAW_PEND.
  - RAW_PEND:
    - when the slot is free, emit pend_raw raw;
    - go to PACK (or FLUSH if tracing=0).
  - tracing falls in PRIME or PACK:
    - go to FLUSH;
    - any input presented that cycle is not accepted.
  - FLUSH:
    - if ptr>0, emit the partial word once the slot is free;
    - then go to IDLE; ptr=0.
- raw_count increments on each raw word loaded into the output register and saturates at all-ones.
- Every emitted word is eventually delivered. None is dropped or overwritten under back-pressure.
- rst_n asserted mid-operation aborts immediately. The partial word is lost.
- Illegal cfg_slots_log2 (0 or > log2 MAX_SLOTS) is clamped to 1 when latched.

Decomposition:
- Package delta_comp_pkg holds:
  - state enum (IDLE, PRIME, PACK, RAW_PEND, FLUSH);
  - INV/mask functions parameterised by P;
  - a range-check function.
- Sub-module delta_lane_pack (one lane) handles:
  - delta subtract;
  - overflow flag;
  - slot insertion into comp_reg[i] given ptr and P.
- It is instantiated N times. Control and the output register stay in the top.

Test Plan:
- Setup for all cases: N=2, DW=32, cfg_slots_log2=2 (S=4, P=8).
- Trace start, ready_out=1:
  - stimulus: tracing=1, inputs {100,200},{99,201},{97,201},{97,190},{96,189};
  - outputs: raw {100,200}, then packed lane0 0x01020001, lane1 0xFF000B01, slots_used=4;
  - raw_count=1.
- Overflow mid-word:
  - stimulus: after base {0,0}, inputs {1,0},{500,0};
  - outputs: partial packed lane0 0xFF808080, lane1 0x00808080, slots_used=1; next cycle raw {500,0};
  - ready_in=0 during RAW_PEND.
- Back-pressure:
  - stimulus: hold ready_out=0 for 5 cycles with valid_in=1;
  - required: ready_in=0 and vector_out stable throughout; no word lost after release; output sequence identical to the unstalled run.
- Flush:
  - stimulus: two deltas into a word, then tracing←0;
  - output: one packed word with slots_used=2, lower slots 0x80; then IDLE; ready_in=0.
- Mode change:
  - stimulus: cfg_slots_log2=1 (P=16) with inputs {0},{−300};
  - output: delta 300 fits, lane0 upper half 0x012C, lower half 0x8000 on flush;
  - changing cfg while tracing has no effect until IDLE.
- Async reset:
  - stimulus: assert rst_n=0 while in RAW_PEND;
  - required: valid_out=0 and raw_count=0 immediately, without waiting for a clock edge.
